mux_lanes: RTL
==============

MUX_LANES -- requirements
Module: mux_lanes

Interface
REQ-001 Parameter WIDTH, default 8, lane and output data width in bits.
REQ-002 Parameter LANES, default 4, number of input lanes; the only supported value is 4.
REQ-003 clk  input  1  single rising-edge clock, fast (output-rate) domain.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 data_in0..data_in3  input  WIDTH each  lane words, held stable by upstream for a full 4-cycle frame.
REQ-006 valid_in  input  4  per-lane valid; bit i qualifies data_in_i.
REQ-007 sample  output  1  high while the next rising edge captures the lanes (cnt==3); combinational from cnt.
REQ-008 data_out  output  WIDTH  serialized lane word, registered.
REQ-009 valid_out  output  1  qualifies data_out, registered.
REQ-010 control  output  2  lane index currently on data_out, registered; matches the demux control encoding.

Function
REQ-011 Internal 2-bit phase counter cnt SHALL increment by 1 every clk edge out of reset and wrap 3->0.
REQ-012 States SHALL be IDLE (after reset, no frame captured) and RUN (at least one frame captured).
REQ-013 On an edge with cnt==3: bank[i]<=data_in_i, bank_v[i]<=valid_in[i] for all i; IDLE->RUN; RUN stays RUN.
REQ-014 On every edge with state RUN before the edge: data_out<=bank[cnt], valid_out<=bank_v[cnt], control<=cnt, all using pre-edge values.
REQ-015 In IDLE the outputs SHALL hold 0; the capture edge itself drives no new output.
REQ-016 Latency: lane i of a frame captured at edge E SHALL appear on the outputs after edge E+1+i.
REQ-017 The lane 3 output edge coincides with the next capture, so throughput SHALL be one word per cycle with no gap.
REQ-018 When bank_v[cnt]==0: valid_out<=0 and data_out<=0; control still advances.
REQ-019 Input changes on edges with cnt!=3 SHALL have no effect on outputs.
REQ-020 sample SHALL be 0 during reset and in the cycle following deassertion until cnt reaches 3.

Reset
REQ-021 Asserting reset_L low SHALL immediately clear cnt, state (IDLE), bank, bank_v, data_out, valid_out and control, independent of clk.
REQ-022 Reset mid-frame SHALL discard the partially emitted frame; the first capture SHALL occur on the 4th edge after deassertion.

Structure
REQ-023 A shared package SHALL hold WIDTH/LANES defaults and the IDLE/RUN state encoding; the demux SHALL use the same package.
REQ-024 The phase counter together with sample generation SHALL be one sub-module, mux_phase_cnt.
REQ-025 All outputs except sample SHALL be flops; there SHALL be no combinational path from the data inputs to data_out.

Verification
REQ-026 Reset release, inputs 0x11/0x22/0x33/0x44 with valid_in=4'hF -> sample at the 4th edge; after edges 5..8, data_out=11,22,33,44 with control=0,1,2,3 and valid_out=1.
REQ-027 Back-to-back frames A0..A3 then B0..B3 -> 8 consecutive valid words with no gap; B0 follows A3 directly.
REQ-028 valid_in=4'b1010 with data AA/BB/CC/DD -> valid_out=0,1,0,1 and data_out=00,BB,00,DD.
REQ-029 Lane inputs changed on edges with cnt in {0,1,2} -> the output frame reflects only the values present at the cnt==3 edge.
REQ-030 reset_L pulsed low between 2 clk edges during lane 1 output -> outputs go 0 immediately, with no clock edge; the next valid word appears after the 5th edge after release.
REQ-031 Loopback into the demux over 16 random frames -> demux lane outputs equal the mux inputs; the scoreboard reports zero mismatches.

Source files
------------

// File: rtl/mux_lanes_pkg.sv
// Shared definitions for the lane mux/demux pair: default sizes and the
// frame-tracking state encoding.
package mux_lanes_pkg;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_LANES = 4;
   localparam int unsigned CNT_W     = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } lane_state_e;

endpackage

// File: rtl/mux_phase_cnt.sv
// Free-running 2-bit frame phase counter; sample flags the capture edge.
module mux_phase_cnt
   import mux_lanes_pkg::*;
(
   input  logic             clk,
   input  logic             reset_L,
   output logic [CNT_W-1:0] cnt,
   output logic             sample
);

   logic [CNT_W-1:0] cnt_r;

   // Phase counter, wraps 3 -> 0 naturally on 2-bit overflow.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         cnt_r <= 2'd0;
      end else begin
         cnt_r <= cnt_r + 2'd1;
      end
   end

   assign cnt    = cnt_r;
   assign sample = (cnt_r == 2'd3);

endmodule

// File: rtl/mux_lanes.sv
// Four-lane to one-lane serializer: captures a frame when cnt==3 and replays
// it one word per cycle, lane 0 first, starting on the following edge.
module mux_lanes
   import mux_lanes_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned LANES = DEF_LANES
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] data_in0,
   input  logic [WIDTH-1:0] data_in1,
   input  logic [WIDTH-1:0] data_in2,
   input  logic [WIDTH-1:0] data_in3,
   input  logic [LANES-1:0] valid_in,
   output logic             sample,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic [1:0]       control
);

   logic [CNT_W-1:0] cnt_s;
   logic             sample_s;
   lane_state_e      state_r;
   lane_state_e      state_nxt_s;
   logic [WIDTH-1:0] lane_s [0:LANES-1];
   logic [WIDTH-1:0] bank_r [0:LANES-1];
   logic [LANES-1:0] bank_v_r;
   logic [WIDTH-1:0] data_out_r;
   logic [WIDTH-1:0] data_nxt_s;
   logic             valid_out_r;
   logic             valid_nxt_s;
   logic [1:0]       control_r;
   logic [1:0]       control_nxt_s;

   mux_phase_cnt u_phase (
      .clk     (clk),
      .reset_L (reset_L),
      .cnt     (cnt_s),
      .sample  (sample_s)
   );

   // Gather the discrete lane ports into an indexable array.
   always_comb begin
      lane_s[0] = data_in0;
      lane_s[1] = data_in1;
      lane_s[2] = data_in2;
      lane_s[3] = data_in3;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and next output word; outputs only advance once a frame exists.
   always_comb begin
      state_nxt_s   = state_r;
      data_nxt_s    = data_out_r;
      valid_nxt_s   = valid_out_r;
      control_nxt_s = control_r;
      case (state_r)
         ST_IDLE: begin
            if (sample_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            state_nxt_s   = ST_RUN;
            control_nxt_s = cnt_s;
            if (bank_v_r[cnt_s]) begin
               data_nxt_s  = bank_r[cnt_s];
               valid_nxt_s = 1'b1;
            end else begin
               data_nxt_s  = {WIDTH{1'b0}};
               valid_nxt_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Frame bank (loaded only on the capture edge) and registered outputs.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < LANES; i++) begin
            bank_r[i] <= {WIDTH{1'b0}};
         end
         bank_v_r    <= {LANES{1'b0}};
         data_out_r  <= {WIDTH{1'b0}};
         valid_out_r <= 1'b0;
         control_r   <= 2'd0;
      end else begin
         if (sample_s) begin
            for (int i = 0; i < LANES; i++) begin
               bank_r[i] <= lane_s[i];
            end
            bank_v_r <= valid_in;
         end
         data_out_r  <= data_nxt_s;
         valid_out_r <= valid_nxt_s;
         control_r   <= control_nxt_s;
      end
   end

   assign sample    = sample_s;
   assign data_out  = data_out_r;
   assign valid_out = valid_out_r;
   assign control   = control_r;

endmodule
